// File: rtl/result_acc_pkg.sv
// rtl/result_acc_pkg.sv - shared types and constants for the result window accumulator
//
// Purpose: holds the two-state FSM enumeration and the sum/counter widths
//          used by result_window_acc and its max-tracking sub-module.
// Ports:   none (package).
package result_acc_pkg;

  localparam int SUM_W = 8;
  localparam int CNT_W = 5;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

endpackage

// File: rtl/result_acc_max.sv
// rtl/result_acc_max.sv - running unsigned maximum of accepted window samples
//
// Purpose: keeps the largest sample loaded since the last clear.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset, zeroes the maximum
//   clr    - synchronous clear of the maximum (window abort or completion)
//   load   - sample on data is accepted this cycle
//   data   - unsigned sample
//   max_o  - current maximum
module result_acc_max #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] max_o
);

  logic [DW-1:0] max_q;
  logic [DW-1:0] max_d;

  // clr beats load so a sample arriving with an abort never leaks into the next window
  always_comb begin
    max_d = max_q;
    if (clr) begin
      max_d = '0;
    end else if (load && (data > max_q)) begin
      max_d = data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max_o = max_q;

endmodule

// File: rtl/result_window_acc.sv
// rtl/result_window_acc.sv - accumulates WINDOW result samples into a sum (and optional max)
//
// Purpose: sums WINDOW accepted unsigned samples, then presents the result with
//          a valid/ready handshake; holds it stable until taken.
// Build option: RESULT_ACC_MAX_EN - when defined, out_max tracks the largest
//               accepted sample; when undefined, out_max is tied to zero.
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous active-high reset (highest priority)
//   in_valid  - input sample present
//   in_data   - unsigned input sample (DW bits)
//   in_ready  - block accepts a sample this cycle (high while accumulating)
//   clear     - synchronous abort of the current window / pending result
//   out_valid - completed window result available
//   out_ready - downstream takes the result
//   out_sum   - sum of the window's samples
//   out_max   - maximum of the window's samples (or zero, see build option)
module result_window_acc
  import result_acc_pkg::*;
#(
  parameter int WINDOW = 4,
  parameter int DW     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [DW-1:0]    out_max
);

  state_t            state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic accept;
  logic out_fire;
  logic win_clr;

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // A completed handshake and an abort both restart the window from zero.
  assign win_clr  = clear | out_fire;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state and datapath update; clear wins over a same-cycle sample
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    if (win_clr) begin
      state_d = ACCUM;
      sum_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      sum_d = sum_q + SUM_W'(in_data);
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(WINDOW)) begin
        state_d = DONE;
      end
    end
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM:   in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign out_sum = sum_q;

`ifdef RESULT_ACC_MAX_EN
  result_acc_max #(
    .DW(DW)
  ) u_max (
    .clk   (clk),
    .reset (reset),
    .clr   (win_clr),
    .load  (accept),
    .data  (in_data),
    .max_o (out_max)
  );
`else
  assign out_max = '0;
`endif

endmodule

// File: tb/tb_result_window_acc.sv
// tb/tb_result_window_acc.sv - self-checking bench for result_window_acc
module tb_result_window_acc;

  localparam int DW = 4;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, clear, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [7:0]    out_sum;
  logic [DW-1:0] out_max;

  logic          in_valid1, clear1, out_ready1;
  logic [DW-1:0] in_data1;
  logic          in_ready1, out_valid1;
  logic [7:0]    out_sum1;
  logic [DW-1:0] out_max1;

  int checks = 0;
  int errors = 0;

  // Reference model: samples of the open window, plus the pending result
  int win_q[$];
  bit pend = 1'b0;
  int pend_sum = 0;
  int pend_max = 0;

  always #5 clk = ~clk;

  result_window_acc #(.WINDOW(W), .DW(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_max(out_max)
  );

  result_window_acc #(.WINDOW(1), .DW(DW)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .clear(clear1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_sum(out_sum1), .out_max(out_max1)
  );

  function automatic int exp_max(input int m);
`ifdef RESULT_ACC_MAX_EN
    return m;
`else
    return 0;
`endif
  endfunction

  // Drive one cycle on the WINDOW=4 instance and advance the reference model
  task automatic step(input bit rst, input bit iv, input int d, input bit clr, input bit ordy);
    int s;
    int m;
    reset = rst; in_valid = iv; in_data = d[DW-1:0]; clear = clr; out_ready = ordy;
    @(posedge clk); #1;
    if (rst) begin
      win_q.delete();
      pend = 1'b0;
    end else if (pend) begin
      if (ordy || clr) pend = 1'b0;
    end else if (clr) begin
      win_q.delete();
    end else if (iv) begin
      win_q.push_back(d);
      if (win_q.size() == W) begin
        s = 0; m = 0;
        foreach (win_q[i]) begin
          s += win_q[i];
          if (win_q[i] > m) m = win_q[i];
        end
        pend = 1'b1; pend_sum = s; pend_max = m;
        win_q.delete();
      end
    end
    reset = 1'b0; in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'd0 || out_max !== '0) begin
      errors++;
      $display("FAIL reset_state in_ready=%0b out_valid=%0b sum=%0d max=%0d required 1 0 0 0",
               in_ready, out_valid, out_sum, out_max);
    end
    step(0, 1, 9, 0, 0); step(0, 1, 9, 0, 0); step(0, 1, 9, 0, 0); step(0, 1, 9, 0, 0);
    // reset in DONE with competing clear/in_valid/out_ready
    step(1, 1, 5, 1, 1);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'd0 || out_max !== '0) begin
      errors++;
      $display("FAIL reset_in_done in_ready=%0b out_valid=%0b sum=%0d max=%0d required 1 0 0 0",
               in_ready, out_valid, out_sum, out_max);
    end
  endtask

  task automatic test_basic();
    step(0, 1, 3, 0, 1); step(0, 1, 8, 0, 1); step(0, 1, 10, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early out_valid=%0b required 0", out_valid);
    end
    step(0, 1, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd22 || out_max !== DW'(exp_max(10))) begin
      errors++;
      $display("FAIL basic_result out_valid=%0b sum=%0d max=%0d required 1 22 %0d",
               out_valid, out_sum, out_max, exp_max(10));
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    step(0, 1, 1, 0, 0); step(0, 1, 2, 0, 0); step(0, 1, 3, 0, 0); step(0, 1, 4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 15, 0, 0);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 8'd10 || out_max !== DW'(exp_max(4))) begin
        errors++;
        $display("FAIL hold_%0d out_valid=%0b in_ready=%0b sum=%0d max=%0d required 1 0 10 %0d",
                 i, out_valid, in_ready, out_sum, out_max, exp_max(4));
      end
    end
    step(0, 1, 15, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
    step(0, 1, 1, 0, 1); step(0, 1, 1, 0, 1); step(0, 1, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_extra_counted out_valid=%0b required 0", out_valid);
    end
    step(0, 1, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd4) begin
      errors++; $display("FAIL hold_next_window out_valid=%0b sum=%0d required 1 4", out_valid, out_sum);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    step(0, 1, 5, 0, 1); step(0, 1, 6, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 15, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd60 || out_max !== DW'(exp_max(15))) begin
      errors++;
      $display("FAIL reset_mid out_valid=%0b sum=%0d max=%0d required 1 60 %0d",
               out_valid, out_sum, out_max, exp_max(15));
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_valid_gaps();
    step(0, 1, 2, 0, 1); step(0, 0, 9, 0, 1); step(0, 1, 4, 0, 1);
    step(0, 0, 9, 0, 1); step(0, 1, 7, 0, 1); step(0, 1, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd14 || out_max !== DW'(exp_max(7))) begin
      errors++;
      $display("FAIL valid_gaps out_valid=%0b sum=%0d max=%0d required 1 14 %0d",
               out_valid, out_sum, out_max, exp_max(7));
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_clear();
    step(0, 1, 2, 0, 1); step(0, 1, 3, 0, 1); step(0, 1, 5, 1, 1);
    step(0, 1, 1, 0, 1); step(0, 1, 1, 0, 1); step(0, 1, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL clear_window out_valid=%0b required 0", out_valid);
    end
    step(0, 1, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd4 || out_max !== DW'(exp_max(1))) begin
      errors++;
      $display("FAIL clear_next out_valid=%0b sum=%0d max=%0d required 1 4 %0d",
               out_valid, out_sum, out_max, exp_max(1));
    end
    // clear while result pending, no handshake: result discarded
    step(0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'd0) begin
      errors++;
      $display("FAIL clear_done out_valid=%0b in_ready=%0b sum=%0d required 0 1 0", out_valid, in_ready, out_sum);
    end
    // clear with a same-cycle handshake
    for (int i = 0; i < 4; i++) step(0, 1, 6, 0, 0);
    step(0, 0, 0, 1, 1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'd0) begin
      errors++;
      $display("FAIL clear_handshake out_valid=%0b in_ready=%0b sum=%0d required 0 1 0", out_valid, in_ready, out_sum);
    end
  endtask

  task automatic test_window1();
    in_valid1 = 1'b1; in_data1 = 4'd7; out_ready1 = 1'b1; clear1 = 1'b0;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    checks++;
    if (out_valid1 !== 1'b1 || out_sum1 !== 8'd7 || out_max1 !== DW'(exp_max(7))) begin
      errors++;
      $display("FAIL w1_first out_valid=%0b sum=%0d max=%0d required 1 7 %0d", out_valid1, out_sum1, out_max1, exp_max(7));
    end
    @(posedge clk); #1;
    in_valid1 = 1'b1; in_data1 = 4'd12;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    checks++;
    if (out_valid1 !== 1'b1 || out_sum1 !== 8'd12 || out_max1 !== DW'(exp_max(12))) begin
      errors++;
      $display("FAIL w1_second out_valid=%0b sum=%0d max=%0d required 1 12 %0d", out_valid1, out_sum1, out_max1, exp_max(12));
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL w1_release out_valid=%0b in_ready=%0b required 0 1", out_valid1, in_ready1);
    end
  endtask

  task automatic test_random();
    bit rst, iv, clr, ordy;
    int d;
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 63) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      ordy = ($urandom_range(0, 1) == 1);
      d    = $urandom_range(0, 15);
      step(rst, iv, d, clr, ordy);
      checks++;
      if (out_valid !== pend || in_ready !== !pend) begin
        errors++;
        $display("FAIL rand_hs_%0d out_valid=%0b in_ready=%0b required %0b %0b", n, out_valid, in_ready, pend, !pend);
      end
      if (pend) begin
        checks++;
        if (out_sum !== 8'(pend_sum) || out_max !== DW'(exp_max(pend_max))) begin
          errors++;
          $display("FAIL rand_result_%0d sum=%0d max=%0d required %0d %0d",
                   n, out_sum, out_max, pend_sum, exp_max(pend_max));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; clear1 = 1'b0; out_ready1 = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_valid_gaps();
    test_clear();
    test_window1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_window_acc.md
RESULT_WINDOW_ACC -- requirements
Module: result_window_acc

Interface
REQ-001 Parameter WINDOW, default 4, samples per window; legal range 1..16.
REQ-002 Parameter DW, default 4, width of each input result sample.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  upstream 4-bit result sample present.
REQ-006 in_data  input  DW  result sample from the 3-bit adder stage, unsigned.
REQ-007 in_ready  output  1  block can accept a sample this cycle.
REQ-008 clear  input  1  synchronous abort of the current window.
REQ-009 out_valid  output  1  completed window result available.
REQ-010 out_ready  input  1  downstream accepts the window result.
REQ-011 out_sum  output  8  unsigned sum of the WINDOW accepted samples.
REQ-012 out_max  output  DW  largest accepted sample in the window (see Configuration).

Function
REQ-013 The FSM SHALL have exactly two states: ACCUM and DONE.
REQ-014 A sample is accepted only on a cycle with in_valid=1 and in_ready=1; in_data on other cycles is ignored.
REQ-015 In ACCUM, in_ready SHALL be 1 and out_valid 0; in DONE, in_ready SHALL be 0 and out_valid 1.
REQ-016 Each accepted sample SHALL add zero-extended in_data to an 8-bit running sum and increment a 5-bit sample counter.
REQ-017 Sum SHALL never overflow: 16 x 15 = 240 fits 8 bits; no saturation logic.
REQ-018 On acceptance of sample number WINDOW, the FSM SHALL enter DONE; out_valid asserts on the following cycle (latency 1).
REQ-019 out_sum and out_max SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 On out_valid=1 and out_ready=1, the FSM SHALL return to ACCUM with sum, max and counter zero on the next cycle.
REQ-021 clear=1 SHALL, in either state, return to ACCUM with sum, max and counter zeroed next cycle, discarding any pending result.
REQ-022 clear=1 with a same-cycle in_valid/in_ready sample: clear wins, sample dropped.
REQ-023 clear=1 with a same-cycle output handshake: the handshake counts as completed; next state ACCUM, zeroed.
REQ-024 WINDOW=1: every accepted sample SHALL produce one result, with out_sum equal to that sample.

Reset
REQ-025 reset=1 SHALL force state ACCUM, sum=0, max=0, counter=0, out_valid=0, in_ready=1 on the next edge.
REQ-026 reset SHALL take priority over clear, in_valid and out_ready, including mid-window and in DONE.

Configuration
REQ-027 Macro RESULT_ACC_MAX_EN defined: out_max tracks the unsigned maximum of accepted samples.
REQ-028 Macro RESULT_ACC_MAX_EN undefined: max register omitted, out_max SHALL be tied to 0; all other behaviour unchanged.

Structure
REQ-029 Package result_acc_pkg SHALL hold the state enumeration (ACCUM, DONE), SUM_W=8 and CNT_W=5 constants.
REQ-030 One sub-module, result_acc_max, SHALL implement the max-tracking register, instantiated only under RESULT_ACC_MAX_EN.
REQ-031 The remaining logic SHALL be flat in result_window_acc.

Verification
REQ-032 WINDOW=4, out_ready=1, samples 3,8,10,1 on consecutive cycles -> out_valid one cycle after 4th sample, out_sum=22, out_max=10 (MAX_EN).
REQ-033 Result pending, out_ready=0 for 3 cycles -> out_sum/out_max stable, in_ready=0, extra in_valid samples not counted.
REQ-034 2 samples (5,6) accepted, then reset for 1 cycle, then 15,15,15,15 -> out_sum=60, out_max=15.
REQ-035 in_valid toggled 1,0,1,0,1,1 with data 2,9,4,9,7,1 -> only 2,4,7,1 counted, out_sum=14.
REQ-036 clear asserted together with 3rd sample -> no result; next 4 samples of 1 give out_sum=4.
REQ-037 WINDOW=1, samples 7 then 12 with out_ready=1 -> two results, out_sum=7 then 12.
